input_pixel_buffer: RTL and testbench

Parametrised input pixel buffer between the AHB read-data path and the rotate pixel core. It packs bytes from each bus beat into a byte-addressed store and tracks which bytes hold valid data. It serves NCH independent pixel-channel reads per request, with per-channel padding and same-cycle write forwarding. Miss flags and a fill count let the core detect reads of bytes not yet fetched.

---
 rtl/input_pixel_buffer_if.sv | 33 +++
 rtl/input_pixel_buffer.sv | 112 +++++++++++
 tb/tb_input_pixel_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/input_pixel_buffer_if.sv
// rtl/input_pixel_buffer_if.sv - bus bundle between AHB read path, rotate pixel core and input_pixel_buffer
interface input_pixel_buffer_if #(
  parameter int AW  = 8,
  parameter int NB  = 4,
  parameter int NCH = 3
) ();
  logic              I_IPB_WRITE;
  logic [8*NB-1:0]   I_IPB_WDATA;
  logic [AW*NB-1:0]  I_IPB_WADDR;
  logic [NB-1:0]     I_IPB_WBE;
  logic              I_IPB_CLEAR;
  logic              I_IPB_RD_REQ;
  logic [AW*NCH-1:0] I_IPB_RADDR;
  logic [NCH-1:0]    I_IPB_PAD;
  logic [8*NCH-1:0]  O_IPB_PIXEL;
  logic              O_IPB_RD_VALID;
  logic [NCH-1:0]    O_IPB_MISS;
  logic              O_IPB_WERR;
  logic [AW:0]       O_IPB_FILL;
  logic              O_IPB_FULL;

  modport slave (
    input  I_IPB_WRITE, I_IPB_WDATA, I_IPB_WADDR, I_IPB_WBE, I_IPB_CLEAR,
    input  I_IPB_RD_REQ, I_IPB_RADDR, I_IPB_PAD,
    output O_IPB_PIXEL, O_IPB_RD_VALID, O_IPB_MISS, O_IPB_WERR, O_IPB_FILL, O_IPB_FULL
  );

  modport master (
    output I_IPB_WRITE, I_IPB_WDATA, I_IPB_WADDR, I_IPB_WBE, I_IPB_CLEAR,
    output I_IPB_RD_REQ, I_IPB_RADDR, I_IPB_PAD,
    input  O_IPB_PIXEL, O_IPB_RD_VALID, O_IPB_MISS, O_IPB_WERR, O_IPB_FILL, O_IPB_FULL
  );
endinterface

// File: rtl/input_pixel_buffer.sv
// rtl/input_pixel_buffer.sv - byte store packing bus beats, serving NCH padded/forwarded pixel reads
module input_pixel_buffer #(
  parameter int         DEPTH     = 192,
  parameter int         AW        = 8,
  parameter int         NB        = 4,
  parameter int         NCH       = 3,
  parameter logic [7:0] PAD_VALUE = 8'h00
) (
  input  logic                I_IPB_HCLK,
  input  logic                I_IPB_HRESET,
  input_pixel_buffer_if.slave bus
);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [8*NCH-1:0] r_pixel;
  logic             r_rd_valid;
  logic [NCH-1:0]   r_miss;
  logic             r_werr;
  logic [AW:0]      r_fill;
  logic             r_full;

  logic [NB-1:0]    w_lane_act;
  logic [NB-1:0]    w_lane_err;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [AW:0]      w_fill_nxt;
  logic [8*NCH-1:0] w_pixel;
  logic [NCH-1:0]   w_miss;

  always_comb begin
    w_lane_act = '0;
    w_lane_err = '0;
    for (int k = 0; k < NB; k++) begin
      if (bus.I_IPB_WRITE && bus.I_IPB_WBE[k]) begin
        if ({1'b0, bus.I_IPB_WADDR[AW*k +: AW]} < L_DEPTH) w_lane_act[k] = 1'b1;
        else                                               w_lane_err[k] = 1'b1;
      end
    end
  end

  // Clear wipes the old vector before this beat's lanes mark theirs valid.
  always_comb begin
    w_valid_nxt = bus.I_IPB_CLEAR ? '0 : r_valid;
    for (int k = 0; k < NB; k++) begin
      if (w_lane_act[k]) w_valid_nxt[bus.I_IPB_WADDR[AW*k +: AW]] = 1'b1;
    end
    w_fill_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fill_nxt = w_fill_nxt + (AW+1)'(w_valid_nxt[i]);
    end
  end

  // Same-cycle lane matches override the array; later lanes override earlier ones.
  always_comb begin
    w_pixel = '0;
    w_miss  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (bus.I_IPB_PAD[c]) begin
        w_pixel[8*c +: 8] = PAD_VALUE;
        w_miss[c]         = 1'b0;
      end else if ({1'b0, bus.I_IPB_RADDR[AW*c +: AW]} >= L_DEPTH) begin
        w_pixel[8*c +: 8] = PAD_VALUE;
        w_miss[c]         = 1'b1;
      end else begin
        w_pixel[8*c +: 8] = r_mem[bus.I_IPB_RADDR[AW*c +: AW]];
        w_miss[c]         = !r_valid[bus.I_IPB_RADDR[AW*c +: AW]];
        for (int k = 0; k < NB; k++) begin
          if (w_lane_act[k] && (bus.I_IPB_WADDR[AW*k +: AW] == bus.I_IPB_RADDR[AW*c +: AW])) begin
            w_pixel[8*c +: 8] = bus.I_IPB_WDATA[8*k +: 8];
            w_miss[c]         = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge I_IPB_HCLK) begin
    for (int k = 0; k < NB; k++) begin
      if (w_lane_act[k]) r_mem[bus.I_IPB_WADDR[AW*k +: AW]] <= bus.I_IPB_WDATA[8*k +: 8];
    end
  end

  always_ff @(posedge I_IPB_HCLK) begin
    if (I_IPB_HRESET) begin
      r_valid    <= '0;
      r_pixel    <= '0;
      r_rd_valid <= 1'b0;
      r_miss     <= '0;
      r_werr     <= 1'b0;
      r_fill     <= '0;
      r_full     <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_fill     <= w_fill_nxt;
      r_full     <= (w_fill_nxt == L_DEPTH);
      r_werr     <= |w_lane_err;
      r_rd_valid <= bus.I_IPB_RD_REQ;
      if (bus.I_IPB_RD_REQ) begin
        r_pixel <= w_pixel;
        r_miss  <= w_miss;
      end
    end
  end

  assign bus.O_IPB_PIXEL    = r_pixel;
  assign bus.O_IPB_RD_VALID = r_rd_valid;
  assign bus.O_IPB_MISS     = r_miss;
  assign bus.O_IPB_WERR     = r_werr;
  assign bus.O_IPB_FILL     = r_fill;
  assign bus.O_IPB_FULL     = r_full;
endmodule

// File: tb/tb_input_pixel_buffer.sv
// tb/tb_input_pixel_buffer.sv - directed self-checking bench for input_pixel_buffer
module tb_input_pixel_buffer;
  localparam int AW = 8, NB = 4, NCH = 3, DEPTH = 192;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  input_pixel_buffer_if #(.AW(AW), .NB(NB), .NCH(NCH)) bus ();

  input_pixel_buffer #(
    .DEPTH(DEPTH), .AW(AW), .NB(NB), .NCH(NCH), .PAD_VALUE(8'h00)
  ) dut (
    .I_IPB_HCLK  (clk),
    .I_IPB_HRESET(rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.I_IPB_WRITE  = 1'b0;
    bus.I_IPB_WDATA  = '0;
    bus.I_IPB_WADDR  = '0;
    bus.I_IPB_WBE    = '0;
    bus.I_IPB_CLEAR  = 1'b0;
    bus.I_IPB_RD_REQ = 1'b0;
    bus.I_IPB_RADDR  = '0;
    bus.I_IPB_PAD    = '0;
  endtask

  task automatic wr(input logic [31:0] addrs, input logic [31:0] data, input logic [3:0] be);
    bus.I_IPB_WRITE = 1'b1;
    bus.I_IPB_WADDR = addrs;
    bus.I_IPB_WDATA = data;
    bus.I_IPB_WBE   = be;
  endtask

  task automatic rd(input logic [23:0] addrs, input logic [2:0] pad);
    bus.I_IPB_RD_REQ = 1'b1;
    bus.I_IPB_RADDR  = addrs;
    bus.I_IPB_PAD    = pad;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr(32'h03020100, 32'hFFFFFFFF, 4'hF);
    rd(24'h020100, 3'b000);
    bus.I_IPB_CLEAR = 1'b1;
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h0) begin n_fail++; $display("FAIL rst_pixel got %h exp %h", bus.O_IPB_PIXEL, 24'h0); end
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got %b exp 0", bus.O_IPB_RD_VALID); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b000) begin n_fail++; $display("FAIL rst_miss got %b exp 000", bus.O_IPB_MISS); end
    n_cmp++; if (bus.O_IPB_WERR !== 1'b0) begin n_fail++; $display("FAIL rst_werr got %b exp 0", bus.O_IPB_WERR); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd0) begin n_fail++; $display("FAIL rst_fill got %0d exp 0", bus.O_IPB_FILL); end
    n_cmp++; if (bus.O_IPB_FULL !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", bus.O_IPB_FULL); end
    rst = 1'b0;
    idle();
    rd(24'h020100, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b1) begin n_fail++; $display("FAIL empty_rd_valid got %b exp 1", bus.O_IPB_RD_VALID); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b111) begin n_fail++; $display("FAIL empty_miss got %b exp 111", bus.O_IPB_MISS); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd0) begin n_fail++; $display("FAIL empty_fill got %0d exp 0", bus.O_IPB_FILL); end
  endtask

  task automatic test_write_read();
    idle();
    wr(32'h03020100, 32'hDDCCBBAA, 4'hF);
    step();
    n_cmp++; if (bus.O_IPB_FILL !== 9'd4) begin n_fail++; $display("FAIL wr_fill got %0d exp 4", bus.O_IPB_FILL); end
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b0) begin n_fail++; $display("FAIL wr_rd_valid got %b exp 0", bus.O_IPB_RD_VALID); end
    idle();
    rd(24'h020100, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'hCCBBAA) begin n_fail++; $display("FAIL rd_pixel got %h exp CCBBAA", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b000) begin n_fail++; $display("FAIL rd_miss got %b exp 000", bus.O_IPB_MISS); end
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b1) begin n_fail++; $display("FAIL rd_valid got %b exp 1", bus.O_IPB_RD_VALID); end
    idle();
    step();
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b0) begin n_fail++; $display("FAIL hold_rd_valid got %b exp 0", bus.O_IPB_RD_VALID); end
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'hCCBBAA) begin n_fail++; $display("FAIL hold_pixel got %h exp CCBBAA", bus.O_IPB_PIXEL); end
  endtask

  task automatic test_forward();
    idle();
    wr(32'h07060504, 32'h44332211, 4'hF);
    rd(24'h060904, 3'b010);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h330011) begin n_fail++; $display("FAIL fwd_pixel got %h exp 330011", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b000) begin n_fail++; $display("FAIL fwd_miss got %b exp 000", bus.O_IPB_MISS); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd8) begin n_fail++; $display("FAIL fwd_fill got %0d exp 8", bus.O_IPB_FILL); end
    idle();
    rd(24'h070605, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h443322) begin n_fail++; $display("FAIL stored_pixel got %h exp 443322", bus.O_IPB_PIXEL); end
  endtask

  task automatic test_duplicate_lanes();
    idle();
    wr(32'h14141414, 32'h80706050, 4'hF);
    step();
    n_cmp++; if (bus.O_IPB_FILL !== 9'd9) begin n_fail++; $display("FAIL dup_fill got %0d exp 9", bus.O_IPB_FILL); end
    idle();
    rd(24'h141414, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h808080) begin n_fail++; $display("FAIL dup_pixel got %h exp 808080", bus.O_IPB_PIXEL); end
    idle();
    wr(32'h14141414, 32'hA1B2C3D4, 4'hF);
    rd(24'h141414, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'hA1A1A1) begin n_fail++; $display("FAIL dup_fwd_pixel got %h exp A1A1A1", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd9) begin n_fail++; $display("FAIL rewrite_fill got %0d exp 9", bus.O_IPB_FILL); end
  endtask

  task automatic test_fill_clear();
    for (int b = 0; b < DEPTH / 4; b++) begin
      logic [7:0] a0;
      a0 = 8'(4 * b);
      idle();
      wr({a0 + 8'd3, a0 + 8'd2, a0 + 8'd1, a0},
         {(a0 + 8'd3) ^ 8'hC3, (a0 + 8'd2) ^ 8'hC3, (a0 + 8'd1) ^ 8'hC3, a0 ^ 8'hC3}, 4'hF);
      step();
    end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd192) begin n_fail++; $display("FAIL full_fill got %0d exp 192", bus.O_IPB_FILL); end
    n_cmp++; if (bus.O_IPB_FULL !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", bus.O_IPB_FULL); end
    idle();
    rd({8'd191, 8'd100, 8'd0}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h7CA7C3) begin n_fail++; $display("FAIL full_pixel got %h exp 7CA7C3", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b000) begin n_fail++; $display("FAIL full_miss got %b exp 000", bus.O_IPB_MISS); end
    idle();
    bus.I_IPB_CLEAR = 1'b1;
    wr(32'h0000000A, 32'h0000005A, 4'b0001);
    rd({8'd12, 8'd11, 8'd10}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'hCFC85A) begin n_fail++; $display("FAIL clr_pixel got %h exp CFC85A", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b000) begin n_fail++; $display("FAIL clr_miss got %b exp 000", bus.O_IPB_MISS); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd1) begin n_fail++; $display("FAIL clr_fill got %0d exp 1", bus.O_IPB_FILL); end
    n_cmp++; if (bus.O_IPB_FULL !== 1'b0) begin n_fail++; $display("FAIL clr_full got %b exp 0", bus.O_IPB_FULL); end
    idle();
    rd({8'd11, 8'd10, 8'd10}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'hC85A5A) begin n_fail++; $display("FAIL post_clr_pixel got %h exp C85A5A", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b100) begin n_fail++; $display("FAIL post_clr_miss got %b exp 100", bus.O_IPB_MISS); end
  endtask

  task automatic test_werr();
    idle();
    wr(32'hC8201F1E, 32'h11223344, 4'b0111);
    step();
    n_cmp++; if (bus.O_IPB_WERR !== 1'b0) begin n_fail++; $display("FAIL werr_disabled got %b exp 0", bus.O_IPB_WERR); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd4) begin n_fail++; $display("FAIL werr_pre_fill got %0d exp 4", bus.O_IPB_FILL); end
    idle();
    wr(32'hC8201F1E, 32'h11223344, 4'hF);
    step();
    n_cmp++; if (bus.O_IPB_WERR !== 1'b1) begin n_fail++; $display("FAIL werr_pulse got %b exp 1", bus.O_IPB_WERR); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd4) begin n_fail++; $display("FAIL werr_fill got %0d exp 4", bus.O_IPB_FILL); end
    idle();
    rd({8'd32, 8'd31, 8'd200}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_WERR !== 1'b0) begin n_fail++; $display("FAIL werr_end got %b exp 0", bus.O_IPB_WERR); end
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h223300) begin n_fail++; $display("FAIL oor_pixel got %h exp 223300", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_MISS !== 3'b001) begin n_fail++; $display("FAIL oor_miss got %b exp 001", bus.O_IPB_MISS); end
  endtask

  task automatic test_back_to_back();
    idle();
    rd({8'd30, 8'd31, 8'd32}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h443322) begin n_fail++; $display("FAIL b2b0_pixel got %h exp 443322", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b0_valid got %b exp 1", bus.O_IPB_RD_VALID); end
    rd({8'd10, 8'd10, 8'd10}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h5A5A5A) begin n_fail++; $display("FAIL b2b1_pixel got %h exp 5A5A5A", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b1_valid got %b exp 1", bus.O_IPB_RD_VALID); end
  endtask

  task automatic test_reset_mid();
    idle();
    wr(32'hC82A2928, 32'h01020304, 4'hF);
    step();
    rst = 1'b1;
    wr(32'h2F2E2D2C, 32'h05060708, 4'hF);
    rd({8'd10, 8'd10, 8'd10}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_PIXEL !== 24'h0) begin n_fail++; $display("FAIL mid_pixel got %h exp 0", bus.O_IPB_PIXEL); end
    n_cmp++; if (bus.O_IPB_RD_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid got %b exp 0", bus.O_IPB_RD_VALID); end
    n_cmp++; if (bus.O_IPB_WERR !== 1'b0) begin n_fail++; $display("FAIL mid_werr got %b exp 0", bus.O_IPB_WERR); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd0) begin n_fail++; $display("FAIL mid_fill got %0d exp 0", bus.O_IPB_FILL); end
    rst = 1'b0;
    idle();
    rd({8'd10, 8'd41, 8'd45}, 3'b000);
    step();
    n_cmp++; if (bus.O_IPB_MISS !== 3'b111) begin n_fail++; $display("FAIL mid_miss got %b exp 111", bus.O_IPB_MISS); end
    n_cmp++; if (bus.O_IPB_FILL !== 9'd0) begin n_fail++; $display("FAIL mid_fill_after got %0d exp 0", bus.O_IPB_FILL); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_forward();
    test_duplicate_lanes();
    test_fill_clear();
    test_werr();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
